// File: rtl/calc_pkg.sv
// Shared widths and ALU opcode encodings for the calculator datapath.
// No logic: constants only, so no latency and no flow control.
package calc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_EQ  = 4'b1100;

endpackage

// File: rtl/calc_datapath_alu.sv
// Combinational ALU: arithmetic, logic, shift/rotate and compare on two operands.
// Zero latency, no state; no backpressure.
module alu
  import calc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        Ctrl,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  output logic [DATA_W-1:0] Result,
  output logic              Carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    Result = '0;
    Carry  = 1'b0;
    case (Ctrl)
      OP_ADD: begin
        sum    = {1'b0, X} + {1'b0, Y};
        Result = sum[DATA_W-1:0];
        Carry  = sum[DATA_W];
      end
      // the 9-bit wrapped difference sets its top bit exactly when X < Y
      OP_SUB: begin
        sum    = {1'b0, X} - {1'b0, Y};
        Result = sum[DATA_W-1:0];
        Carry  = sum[DATA_W];
      end
      OP_AND: Result = X & Y;
      OP_OR:  Result = X | Y;
      OP_NOT: Result = ~X;
      OP_XOR: Result = X ^ Y;
      OP_NOR: Result = ~(X | Y);
      OP_SLL: Result = Y << X[2:0];
      OP_SRL: Result = Y >> X[2:0];
      OP_SRA: Result = {X[DATA_W-1], X[DATA_W-1:1]};
      OP_ROL: Result = {X[DATA_W-2:0], X[DATA_W-1]};
      OP_ROR: Result = {X[0], X[DATA_W-1:1]};
      OP_EQ:  Result = {{(DATA_W-1){1'b0}}, (X == Y)};
      default: Result = '0;
    endcase
  end

endmodule

// File: rtl/calc_datapath_regfile.sv
// Register file with r0 hardwired to zero, two combinational read ports, no write bypass.
// Writes commit at the next rising edge; no backpressure (always accepts).
module register_file
  import calc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] rw,
  input  logic [ADDR_W-1:0] rx,
  input  logic [ADDR_W-1:0] ry,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] bus_x,
  output logic [DATA_W-1:0] bus_y
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d    = regs_q;
    regs_d[0] = '0;
    if (wen && (rw != '0)) begin
      regs_d[rw] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // r0 is muxed to zero so it reads 0 even before the first reset
  assign bus_x = (rx == '0) ? '0 : regs_q[rx];
  assign bus_y = (ry == '0) ? '0 : regs_q[ry];

endmodule

// File: rtl/calc_datapath.sv
// Calculator datapath: register file -> operand mux -> ALU -> write-back; ZERO_FLAG_EN adds a Zero output.
// Outputs combinational, write-back commits next rising edge; no backpressure.
module calc_datapath
  import calc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] RW,
  input  logic [ADDR_W-1:0] RX,
  input  logic [ADDR_W-1:0] RY,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Sel,
  input  logic [3:0]        Ctrl,
  output logic [DATA_W-1:0] busX,
  output logic [DATA_W-1:0] busY,
  output logic [DATA_W-1:0] Result,
  output logic              Carry
`ifdef ZERO_FLAG_EN
  ,
  output logic              Zero
`endif
);

  logic [DATA_W-1:0] op_x;

  assign op_x = Sel ? busX : DataIn;

  register_file #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk  (Clk),
    .rst  (Rst),
    .wen  (WEN),
    .rw   (RW),
    .rx   (RX),
    .ry   (RY),
    .wdata(Result),
    .bus_x(busX),
    .bus_y(busY)
  );

  alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .Ctrl  (Ctrl),
    .X     (op_x),
    .Y     (busY),
    .Result(Result),
    .Carry (Carry)
  );

`ifdef ZERO_FLAG_EN
  assign Zero = (Result == '0);
`endif

endmodule

// File: tb/tb_calc_datapath.sv
// Directed plus random bench for calc_datapath against an arithmetic reference model.
module tb_calc_datapath;

  logic       Clk;
  logic       Rst;
  logic       WEN;
  logic [2:0] RW;
  logic [2:0] RX;
  logic [2:0] RY;
  logic [7:0] DataIn;
  logic       Sel;
  logic [3:0] Ctrl;
  logic [7:0] busX;
  logic [7:0] busY;
  logic [7:0] Result;
  logic       Carry;
`ifdef ZERO_FLAG_EN
  logic       Zero;
`endif

  int checks = 0;
  int errors = 0;
  int model [8];

  calc_datapath dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .WEN   (WEN),
    .RW    (RW),
    .RX    (RX),
    .RY    (RY),
    .DataIn(DataIn),
    .Sel   (Sel),
    .Ctrl  (Ctrl),
    .busX  (busX),
    .busY  (busY),
    .Result(Result),
    .Carry (Carry)
`ifdef ZERO_FLAG_EN
    ,
    .Zero  (Zero)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Returns carry*256 + result, computed with plain integer arithmetic.
  function automatic int ref_alu(input int op, input int x, input int y);
    int r;
    int c;
    r = 0;
    c = 0;
    case (op)
      0:  begin r = (x + y) % 256; c = (x + y > 255) ? 1 : 0; end
      1:  begin r = (x - y + 256) % 256; c = (x < y) ? 1 : 0; end
      2:  r = x & y;
      3:  r = x | y;
      4:  r = 255 - x;
      5:  r = x ^ y;
      6:  r = 255 - (x | y);
      7:  r = (y * (1 << (x % 8))) % 256;
      8:  r = y / (1 << (x % 8));
      9:  r = x / 2 + ((x >= 128) ? 128 : 0);
      10: r = (x * 2) % 256 + x / 128;
      11: r = x / 2 + (x % 2) * 128;
      12: r = (x == y) ? 1 : 0;
      default: r = 0;
    endcase
    return c * 256 + r;
  endfunction

  function automatic int expected_out();
    int x;
    x = Sel ? model[RX] : int'(DataIn);
    return ref_alu(int'(Ctrl), x, model[RY]);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wen, input logic [2:0] rw,
                       input logic [2:0] rx, input logic [2:0] ry, input logic [7:0] din,
                       input logic sel, input logic [3:0] ctrl);
    Rst = rst; WEN = wen; RW = rw; RX = rx; RY = ry;
    DataIn = din; Sel = sel; Ctrl = ctrl;
    #2;
  endtask

  task automatic model_check(input string tag);
    int e;
    e = expected_out();
    chk({tag, "_busX"}, busX, model[RX][7:0]);
    chk({tag, "_busY"}, busY, model[RY][7:0]);
    chk({tag, "_res"}, Result, e[7:0]);
    chk({tag, "_carry"}, {7'd0, Carry}, {7'd0, e[8]});
`ifdef ZERO_FLAG_EN
    chk({tag, "_zero"}, {7'd0, Zero}, {7'd0, (e[7:0] == 8'd0)});
`endif
  endtask

  // Advance one edge and update the model from the pre-edge inputs.
  task automatic tick();
    int e;
    e = expected_out();
    @(posedge Clk);
    if (Rst) begin
      for (int i = 0; i < 8; i++) model[i] = 0;
    end else if (WEN && RW != 3'd0) begin
      model[RW] = e % 256;
    end
    #1;
  endtask

  task automatic load(input logic [2:0] r, input logic [7:0] v);
    drive(1'b0, 1'b1, r, 3'd0, 3'd0, v, 1'b0, 4'b0000);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 0;
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 4'b0000);
    @(posedge Clk);
    #1;

    // Before any reset: r0 still reads zero and r3 can be loaded
    drive(1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 8'h55, 1'b0, 4'b0000);
    chk("r0_prereset", busY, 8'h00);
    chk("load_res_prereset", Result, 8'h55);
    tick();
    drive(1'b0, 1'b0, 3'd0, 3'd3, 3'd0, 8'h00, 1'b0, 4'b0000);
    chk("r3_loaded", busX, 8'h55);

    drive(1'b1, 1'b0, 3'd0, 3'd3, 3'd5, 8'h00, 1'b0, 4'b0000);
    tick();
    drive(1'b0, 1'b0, 3'd0, 3'd3, 3'd5, 8'h00, 1'b0, 4'b0000);
    chk("reset_busX", busX, 8'h00);
    chk("reset_busY", busY, 8'h00);
    model_check("post_reset");

    load(3'd2, 8'h3C);
    drive(1'b0, 1'b0, 3'd0, 3'd2, 3'd0, 8'h00, 1'b0, 4'b0000);
    chk("r2_load", busX, 8'h3C);
    load(3'd0, 8'h3C);
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 4'b0000);
    chk("r0_protect", busX, 8'h00);

    load(3'd1, 8'hF0);
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 8'h20, 1'b0, 4'b0000);
    chk("add_res", Result, 8'h10);
    chk("add_carry", {7'd0, Carry}, 8'h01);
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 8'h0F, 1'b0, 4'b0000);
    chk("add_res2", Result, 8'hFF);
    chk("add_carry2", {7'd0, Carry}, 8'h00);

    load(3'd1, 8'h07);
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 8'h05, 1'b0, 4'b0001);
    chk("sub_res", Result, 8'hFE);
    chk("sub_borrow", {7'd0, Carry}, 8'h01);
    load(3'd1, 8'h05);
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 8'h07, 1'b0, 4'b0001);
    chk("sub_res2", Result, 8'h02);
    chk("sub_borrow2", {7'd0, Carry}, 8'h00);

    load(3'd4, 8'h81);
    load(3'd1, 8'h07);
    drive(1'b0, 1'b0, 3'd0, 3'd4, 3'd1, 8'h00, 1'b1, 4'b0111);
    chk("sll", Result, 8'h0E);
    drive(1'b0, 1'b0, 3'd0, 3'd4, 3'd1, 8'h00, 1'b1, 4'b1001);
    chk("sra", Result, 8'hC0);
    drive(1'b0, 1'b0, 3'd0, 3'd4, 3'd1, 8'h00, 1'b1, 4'b1010);
    chk("rol", Result, 8'h03);
    drive(1'b0, 1'b0, 3'd0, 3'd4, 3'd1, 8'h00, 1'b1, 4'b1011);
    chk("ror", Result, 8'hC0);
    drive(1'b0, 1'b0, 3'd0, 3'd4, 3'd4, 8'h00, 1'b1, 4'b1100);
    chk("eq_same", Result, 8'h01);
    drive(1'b0, 1'b0, 3'd0, 3'd4, 3'd1, 8'h00, 1'b1, 4'b1111);
    chk("op_f_res", Result, 8'h00);
    chk("op_f_carry", {7'd0, Carry}, 8'h00);

    load(3'd6, 8'h11);
    drive(1'b0, 1'b1, 3'd6, 3'd6, 3'd0, 8'h22, 1'b0, 4'b0000);
    chk("rdw_old", busX, 8'h11);
    tick();
    drive(1'b0, 1'b0, 3'd0, 3'd6, 3'd0, 8'h00, 1'b0, 4'b0000);
    chk("rdw_new", busX, 8'h22);
    drive(1'b1, 1'b1, 3'd6, 3'd6, 3'd0, 8'h33, 1'b0, 4'b0000);
    tick();
    drive(1'b0, 1'b0, 3'd0, 3'd6, 3'd0, 8'h00, 1'b0, 4'b0000);
    chk("rst_priority", busX, 8'h00);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
      model_check("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_datapath.md
Name: calc_datapath

Overview:
- 8-bit calculator datapath: an 8-entry register file (sub-module register_file) feeding a combinational ALU (sub-module alu).
- The ALU result is written back into the register file.
- ALU operand X comes either from read port X or from an external input; operand Y always comes from read port Y.
- Sits below the calculator top level; all sequencing (which registers, which op) is driven externally each cycle.

Parameters:
- DATA_W, 8, datapath width in bits.
- ADDR_W, 3, register address width; NREG = 2**ADDR_W = 8 registers.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- WEN  input  1  write enable for the register file.
- RW  input  ADDR_W  write address.
- RX  input  ADDR_W  read address, port X.
- RY  input  ADDR_W  read address, port Y.
- DataIn  input  DATA_W  external operand.
- Sel  input  1  1: ALU X = busX; 0: ALU X = DataIn.
- Ctrl  input  4  ALU opcode.
- busX  output  DATA_W  register file read data, port X.
- busY  output  DATA_W  register file read data, port Y; also ALU operand Y.
- Result  output  DATA_W  ALU result, which is also the write-back data.
- Carry  output  1  ALU carry/borrow flag.

Behaviour:
- Reset and clocking:
  - Single clock domain.
  - Rst sampled at the rising edge of Clk clears r1..r7 to 0.
  - Rst has priority over a simultaneous write.
- Register 0:
  - r0 reads 0 at all times.
  - Writes to RW=0 are ignored.
- Write:
  - At a rising edge with WEN=1, Rst=0 and RW!=0, the register at RW takes Result.
  - WEN=0 leaves all registers unchanged.
- Read:
  - busX = reg[RX] and busY = reg[RY], combinational, with no write bypass.
  - A read of the register being written in the same cycle returns the old value; the new value is visible after the edge.
  - RX==RY is legal.
- Operand mux: X = Sel ? busX : DataIn; Y = busY.
- ALU opcodes (combinational, same-cycle):
  - 0000 ADD: Result = X+Y; Carry = bit 8 of the 9-bit unsigned sum.
  - 0001 SUB: Result = X-Y; Carry = 1 when X<Y unsigned (borrow).
  - 0010 AND: X&Y.
  - 0011 OR: X|Y.
  - 0100 NOT: ~X.
  - 0101 XOR: X^Y.
  - 0110 NOR: ~(X|Y).
  - 0111 SLL: Y << X[2:0].
  - 1000 SRL: Y >> X[2:0], zero fill.
  - 1001 SRA: {X[7],X[7:1]}.
  - 1010 ROL: {X[6:0],X[7]}.
  - 1011 ROR: {X[0],X[7:1]}.
  - 1100 EQ: Result = (X==Y) ? 1 : 0.
  - 1101-1111: Result = 0.
- Carry is 0 for every opcode except ADD and SUB. Results wrap modulo 2**DATA_W.
- Latency: Result and Carry are combinational from the inputs; write-back commits at the next rising edge (1 cycle).
- After reset:
  - busX = busY = 0.
  - Result and Carry follow the ALU equations with register data 0.
  - No output is registered.

Optional Feature:
- Macro ZERO_FLAG_EN.
- Defined: extra output port Zero (1 bit) = (Result == 0), combinational, valid for every opcode.
- Not defined: no Zero port; behaviour otherwise identical.

Decomposition:
- Shared package calc_pkg holds:
  - DATA_W and ADDR_W defaults.
  - The 4-bit opcode constants OP_ADD .. OP_EQ as named localparams/enum.
- Sub-module register_file: 8x8 storage, r0 hardwired to zero, synchronous reset and write, two combinational read ports.
- Sub-module alu: purely combinational, inputs Ctrl, X, Y; outputs Result, Carry.
- calc_datapath instantiates both and implements the Sel mux.

Test Plan:
- Reset then read: Rst=1 for 1 edge, then RX=3, RY=5 -> busX=0, busY=0. Prior to reset, load r3=0x55 -> after reset, r3 reads 0.
- Load and r0 protection:
  - Sel=0, RY=0, Ctrl=ADD, DataIn=0x3C, WEN=1, RW=2 -> after the edge, r2=0x3C.
  - Same stimulus with RW=0 -> r0 still reads 0.
- ADD carry: r1=0xF0, Sel=0, DataIn=0x20, RY=1, Ctrl=ADD -> Result=0x10, Carry=1. With DataIn=0x0F -> Result=0xFF, Carry=0.
- SUB borrow: DataIn=0x05, r1=0x07, Ctrl=SUB -> Result=0xFE, Carry=1. With DataIn=0x07, r1=0x05 -> Result=0x02, Carry=0.
- Shifts/rotates, Sel=1:
  - r4=0x81 as X, r1=0x07 as Y.
  - SLL with X[2:0]=1 -> 0x0E.
  - SRA -> 0xC0.
  - ROL -> 0x03.
  - ROR -> 0xC0.
  - EQ of r4 against r4 -> 0x01.
  - Ctrl=1111 -> 0x00.
- Read-during-write and reset priority:
  - r6=0x11; write Result=0x22 to r6 with RX=6 -> busX shows 0x11 before the edge and 0x22 after.
  - Rst=1 and WEN=1 at the same edge -> r6=0.
